capture_ctrl: RTL and testbench



---
 rtl/la_pkg.sv | 16 +
 rtl/capture_ctrl_if.sv | 10 +
 rtl/capture_ctrl_smpl_decim.sv | 30 +++
 rtl/capture_ctrl.sv | 146 ++++++++++++++
 tb/tb_capture_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture FSM states and RAM geometry
// common to capture_ctrl and cmd_cfg.
package la_pkg;

  localparam int ENTRIES = 384;  // depth of each channel RAM
  localparam int LOG2    = 9;    // RAM address width

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    POST,
    DONE,
    WAIT
  } cap_state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Shared write port of the five channel RAMs: one enable, one address.
interface capture_ctrl_if;

  logic                     we;
  logic [la_pkg::LOG2-1:0]  waddr;

  modport master (output we, output waddr);
  modport slave  (input  we, input  waddr);

endinterface

// File: rtl/capture_ctrl_smpl_decim.sv
// Sample decimator: keeps one of every 2^decimator base-rate strobes.
module smpl_decim (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       count_en,
  input  logic       smpl_en,
  input  logic [3:0] decimator,
  output logic       cap
);

  logic [14:0] dec_cnt;
  logic [14:0] mask;

  // All-ones in the low 'decimator' bits; decimator=15 yields 15'h7fff.
  assign mask = ~(15'h7fff << decimator);
  assign cap  = smpl_en && ((dec_cnt & mask) == mask);

  // Strobe counter, restarted before every capture.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst || clear) begin
      dec_cnt <= '0;
    end else if (count_en && smpl_en) begin
      dec_cnt <= dec_cnt + 15'd1;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: decimated RAM writes, pre-trigger arming, post-trigger
// count and a one-cycle completion pulse towards cmd_cfg.
module capture_ctrl
  import la_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 cap_done_bit,
  input  logic                 smpl_en,
  input  logic [3:0]           decimator,
  input  logic [LOG2-1:0]      trig_pos,
  input  logic                 triggered,
  capture_ctrl_if.master       ram,
  output logic [LOG2-1:0]      ram_addr,
  output logic                 armed,
  output logic                 capturing,
  output logic                 set_capture_done
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   FULL = (LOG2 + 1)'(ENTRIES);

  cap_state_t       state;
  logic             cap;
  logic             active;
  logic             seen;
  logic [LOG2:0]    smpl_cnt;
  logic [LOG2:0]    smpl_nxt;
  logic [LOG2:0]    cnt_after;
  logic [LOG2-1:0]  post_cnt;
  logic [LOG2-1:0]  post_nxt;
  logic [LOG2-1:0]  tp;
  logic [LOG2-1:0]  tp_in;
  logic [LOG2-1:0]  waddr_nxt;
  logic             arm_cmp;

  assign active    = (state == RUN) || (state == POST);
  assign ram.we    = cap && active;
  assign tp_in     = (trig_pos > LAST) ? LAST : trig_pos;
  assign waddr_nxt = (ram.waddr == LAST) ? '0 : ram.waddr + 1'b1;
  assign smpl_nxt  = (smpl_cnt == FULL) ? FULL : smpl_cnt + 1'b1;
  assign cnt_after = ram.we ? smpl_nxt : smpl_cnt;
  assign post_nxt  = post_cnt + 1'b1;
  // Enough history stored that tp further samples cannot overwrite it.
  assign arm_cmp   = (cnt_after + {1'b0, tp}) >= FULL;

  smpl_decim u_decim (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == IDLE),
    .count_en  (active),
    .smpl_en   (smpl_en),
    .decimator (decimator),
    .cap       (cap)
  );

  // Capture FSM with its address, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ram.waddr        <= '0;
      ram_addr         <= '0;
      smpl_cnt         <= '0;
      post_cnt         <= '0;
      tp               <= '0;
      seen             <= 1'b0;
      armed            <= 1'b0;
      capturing        <= 1'b0;
      set_capture_done <= 1'b0;
    end else begin
      set_capture_done <= 1'b0;
      case (state)
        IDLE: begin
          seen  <= 1'b0;
          armed <= 1'b0;
          if (run && !cap_done_bit) begin
            state     <= RUN;
            capturing <= 1'b1;
            ram.waddr <= '0;
            smpl_cnt  <= '0;
            post_cnt  <= '0;
            tp        <= tp_in;
          end
        end
        RUN: begin
          if (!run) begin
            state     <= IDLE;
            capturing <= 1'b0;
            armed     <= 1'b0;
          end else begin
            // A write in the trigger cycle still belongs to pre-trigger data.
            if (ram.we) begin
              ram.waddr <= waddr_nxt;
              ram_addr  <= ram.waddr;
              smpl_cnt  <= smpl_nxt;
            end
            if (triggered && armed) begin
              armed <= 1'b0;
              if (tp == '0) begin
                state            <= DONE;
                capturing        <= 1'b0;
                set_capture_done <= 1'b1;
              end else begin
                state <= POST;
              end
            end else begin
              armed <= arm_cmp;
            end
          end
        end
        POST: begin
          if (!run) begin
            state     <= IDLE;
            capturing <= 1'b0;
          end else if (ram.we) begin
            ram.waddr <= waddr_nxt;
            ram_addr  <= ram.waddr;
            post_cnt  <= post_nxt;
            if (post_nxt == tp) begin
              state            <= DONE;
              capturing        <= 1'b0;
              set_capture_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= WAIT;
        end
        WAIT: begin
          // Wait for cmd_cfg to acknowledge (bit seen set) and then clear it.
          if (cap_done_bit) begin
            seen <= 1'b1;
          end
          if (!run || (seen && !cap_done_bit)) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed testbench for capture_ctrl with hand-computed expectations.
// Cycle c counts RUN cycles from the IDLE->RUN edge; one write per cycle
// with decimator=0 and a continuous strobe.
module tb_capture_ctrl;
  import la_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic            cap_done_bit;
  logic            smpl_en;
  logic [3:0]      decimator;
  logic [LOG2-1:0] trig_pos;
  logic            triggered;
  logic [LOG2-1:0] ram_addr;
  logic            armed;
  logic            capturing;
  logic            set_capture_done;

  capture_ctrl_if ram_if ();

  capture_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .cap_done_bit     (cap_done_bit),
    .smpl_en          (smpl_en),
    .decimator        (decimator),
    .trig_pos         (trig_pos),
    .triggered        (triggered),
    .ram              (ram_if),
    .ram_addr         (ram_addr),
    .armed            (armed),
    .capturing        (capturing),
    .set_capture_done (set_capture_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    run       = 1'b0;
    smpl_en   = 1'b0;
    triggered = 1'b0;
    step();
    step();
  endtask

  // Configure and raise run; returns in RUN cycle 0.
  task automatic start(input logic [3:0] dec, input int tpos, input logic trig);
    decimator = dec;
    trig_pos  = tpos[LOG2-1:0];
    triggered = trig;
    smpl_en   = 1'b1;
    run       = 1'b1;
    step();
  endtask

  initial begin
    int arm_c;
    int done_c;
    int pulses;

    rst = 1'b1; run = 1'b0; cap_done_bit = 1'b0; smpl_en = 1'b0;
    triggered = 1'b0; decimator = '0; trig_pos = '0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_we",        ram_if.we,        0);
    check("rst_waddr",     ram_if.waddr,     0);
    check("rst_ram_addr",  ram_addr,         0);
    check("rst_armed",     armed,            0);
    check("rst_capturing", capturing,        0);
    check("rst_done",      set_capture_done, 0);
    step();

    // T1: tp=100, trigger held. Armed after 284 writes; the trigger-cycle write
    // (c=284) is pre-trigger, then 100 post writes c=285..384 end at address 0.
    start(4'd0, 100, 1'b1);
    arm_c = -1; done_c = -1;
    for (int c = 0; c < 600 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("t1_we_c0", ram_if.we, 1);
        check("t1_capturing_c0", capturing, 1);
      end
      if (c == 10)  check("t1_waddr_c10", ram_if.waddr, 10);
      if (c == 300) check("t1_capturing_post", capturing, 1);
      if (armed && arm_c < 0) arm_c = c;
      if (set_capture_done) begin
        done_c = c;
        check("t1_ram_addr", ram_addr, 0);
        check("t1_we_done", ram_if.we, 0);
      end
      step();
    end
    check("t1_arm_cycle", arm_c, 284);
    check("t1_done_cycle", done_c, 385);
    @(negedge clk);
    check("t1_pulse_one_cycle", set_capture_done, 0);
    check("t1_capturing_wait", capturing, 0);
    step();

    // T2: decimator=2 -> write at c=4n+3 with waddr n; early trigger ignored.
    go_idle();
    start(4'd2, 100, 1'b1);
    for (int c = 0; c <= 1540; c++) begin
      if (c == 50) triggered = 1'b0;
      @(negedge clk);
      if (c < 8) check($sformatf("t2_we_c%0d", c), ram_if.we, (c == 3 || c == 7) ? 1 : 0);
      if (c == 8) check("t2_waddr_c8", ram_if.waddr, 2);
      if (c == 60) check("t2_unarmed_trig_armed", armed, 0);
      if (c == 1135) check("t2_armed_before", armed, 0);
      if (c == 1136) check("t2_armed_after", armed, 1);
      if (c == 1535) begin
        check("t2_waddr_last", ram_if.waddr, 383);
        check("t2_we_last", ram_if.we, 1);
      end
      if (c == 1536) begin
        check("t2_waddr_wrap", ram_if.waddr, 0);
        check("t2_ram_addr_wrap", ram_addr, 383);
      end
      if (c == 1540) begin
        check("t2_ram_addr_after_wrap", ram_addr, 0);
        check("t2_waddr_after_wrap", ram_if.waddr, 1);
        check("t2_still_capturing", capturing, 1);
      end
      step();
    end

    // T3: tp=0. 384 writes arm it, trigger in a write-free cycle -> DONE.
    go_idle();
    start(4'd0, 0, 1'b0);
    for (int c = 0; c <= 386; c++) begin
      smpl_en   = (c != 384);
      triggered = (c >= 384);
      @(negedge clk);
      if (c == 383) check("t3_armed_383", armed, 0);
      if (c == 384) begin
        check("t3_armed_384", armed, 1);
        check("t3_we_trig", ram_if.we, 0);
      end
      if (c == 385) begin
        check("t3_done", set_capture_done, 1);
        check("t3_ram_addr", ram_addr, 383);
        check("t3_we_done", ram_if.we, 0);
      end
      if (c == 386) begin
        check("t3_done_clear", set_capture_done, 0);
        check("t3_we_wait", ram_if.we, 0);
      end
      step();
    end

    // T4: trig_pos=500 is clamped to 383: armed after one write, 383 post writes.
    go_idle();
    start(4'd0, 500, 1'b1);
    done_c = -1;
    for (int c = 0; c < 600 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 0) check("t4_armed_c0", armed, 0);
      if (c == 1) check("t4_armed_c1", armed, 1);
      if (set_capture_done) begin
        done_c = c;
        check("t4_ram_addr", ram_addr, 0);
      end
      step();
    end
    check("t4_done_cycle", done_c, 385);

    // T5: run dropped in POST -> IDLE, no pulse, ram_addr holds.
    go_idle();
    start(4'd0, 100, 1'b1);
    pulses = 0;
    for (int c = 0; c <= 450; c++) begin
      if (c == 300) begin run = 1'b0; smpl_en = 1'b0; end
      if (c == 301) smpl_en = 1'b1;
      @(negedge clk);
      if (c == 299) check("t5_in_post", capturing, 1);
      if (c == 301) begin
        check("t5_capturing", capturing, 0);
        check("t5_we", ram_if.we, 0);
        check("t5_ram_addr_hold", ram_addr, 299);
      end
      if (set_capture_done) pulses++;
      step();
    end
    check("t5_no_pulse", pulses, 0);

    // T6: rst mid-RUN, then a full capture and the WAIT handshake.
    go_idle();
    start(4'd0, 100, 1'b1);
    for (int c = 0; c <= 51; c++) begin
      if (c == 50) rst = 1'b1;
      if (c == 51) begin rst = 1'b0; run = 1'b0; end
      @(negedge clk);
      if (c == 51) begin
        check("t6_rst_we",        ram_if.we,        0);
        check("t6_rst_waddr",     ram_if.waddr,     0);
        check("t6_rst_ram_addr",  ram_addr,         0);
        check("t6_rst_armed",     armed,            0);
        check("t6_rst_capturing", capturing,        0);
      end
      step();
    end
    start(4'd0, 100, 1'b1);
    done_c = -1;
    for (int c = 0; c < 600 && done_c < 0; c++) begin
      @(negedge clk);
      if (set_capture_done) done_c = c;
      step();
    end
    check("t6_done_cycle", done_c, 385);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t6_wait_hold%0d", k), ram_if.we, 0);
      step();
    end
    cap_done_bit = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("t6_wait_ack%0d", k), ram_if.we, 0);
      step();
    end
    cap_done_bit = 1'b0;
    @(negedge clk);
    check("t6_wait_release", capturing, 0);
    step();
    @(negedge clk);
    check("t6_idle_we", ram_if.we, 0);
    check("t6_idle_capturing", capturing, 0);
    step();
    @(negedge clk);
    check("t6_restart_we", ram_if.we, 1);
    check("t6_restart_waddr", ram_if.waddr, 0);
    check("t6_restart_capturing", capturing, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
